// File: rtl/stage_execute_if.sv
`default_nettype none
// ============================================================================
// Module   : stage_execute_if
// Purpose  : ID/EX to EX/MEM bundle seen by the execute stage.
// Revision : 1.0 - initial release
// ============================================================================
interface stage_execute_if #(
    parameter int WIDTH = 32
);
    logic             ValidE;
    logic             FlushE;
    logic             RegWriteE;
    logic             MemtoRegE;
    logic             MemWriteE;
    logic             ALUSrcE;
    logic             FlagsWriteE;
    logic [2:0]       ALUControlE;
    logic [3:0]       WA3E;
    logic [WIDTH-1:0] rd1E;
    logic [WIDTH-1:0] rd2E;
    logic [WIDTH-1:0] ExtImmE;

    logic             StallE;
    logic             ValidM;
    logic             RegWriteM;
    logic             MemtoRegM;
    logic             MemWriteM;
    logic [3:0]       WA3M;
    logic [WIDTH-1:0] ALUResultM;
    logic [WIDTH-1:0] WriteDataM;
    logic [3:0]       FlagsNZCV;

    modport master (
        output ValidE, FlushE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE,
               FlagsWriteE, ALUControlE, WA3E, rd1E, rd2E, ExtImmE,
        input  StallE, ValidM, RegWriteM, MemtoRegM, MemWriteM, WA3M,
               ALUResultM, WriteDataM, FlagsNZCV
    );

    modport slave (
        input  ValidE, FlushE, RegWriteE, MemtoRegE, MemWriteE, ALUSrcE,
               FlagsWriteE, ALUControlE, WA3E, rd1E, rd2E, ExtImmE,
        output StallE, ValidM, RegWriteM, MemtoRegM, MemWriteM, WA3M,
               ALUResultM, WriteDataM, FlagsNZCV
    );
endinterface
`default_nettype wire

// File: rtl/stage_execute.sv
`default_nettype none
// ============================================================================
// Module   : stage_execute
// Purpose  : Execute stage - ALU, NZCV flags, shift-add MUL sequencer, EX/MEM regs.
// Revision : 1.0 - initial release
// ============================================================================
module stage_execute #(
    parameter int WIDTH    = 32,
    parameter int MUL_ITER = 32
) (
    input  wire logic        clk,
    input  wire logic        reset,
    stage_execute_if.slave   ex
);
    localparam int c_cnt_w = (MUL_ITER > 1) ? $clog2(MUL_ITER) : 1;
    localparam int c_sh_w  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(MUL_ITER - 1);

    localparam logic [2:0] c_op_add  = 3'b000;
    localparam logic [2:0] c_op_sub  = 3'b001;
    localparam logic [2:0] c_op_and  = 3'b010;
    localparam logic [2:0] c_op_or   = 3'b011;
    localparam logic [2:0] c_op_xor  = 3'b100;
    localparam logic [2:0] c_op_shl  = 3'b101;
    localparam logic [2:0] c_op_mul  = 3'b110;
    localparam logic [2:0] c_op_movb = 3'b111;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [c_cnt_w-1:0] r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic               r_mul_regwrite;
    logic               r_mul_memtoreg;
    logic               r_mul_memwrite;
    logic               r_mul_flagswrite;
    logic [3:0]         r_mul_wa3;
    logic [WIDTH-1:0]   r_mul_wdata;

    logic               r_validm;
    logic               r_regwritem;
    logic               r_memtoregm;
    logic               r_memwritem;
    logic [3:0]         r_wa3m;
    logic [WIDTH-1:0]   r_resultm;
    logic [WIDTH-1:0]   r_wdatam;
    logic [3:0]         r_flags;

    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_srcb;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_diff;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_c;
    logic               w_alu_v;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_is_mul;
    logic               w_start_mul;
    logic               w_commit_single;
    logic               w_mul_last;
    logic               w_mul_done;

    assign w_a    = ex.rd1E;
    assign w_srcb = ex.ALUSrcE ? ex.ExtImmE : ex.rd2E;
    assign w_sum  = {1'b0, w_a} + {1'b0, w_srcb};
    assign w_diff = {1'b0, w_a} + {1'b0, ~w_srcb} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = r_flags[1];
        w_alu_v   = r_flags[0];
        case (ex.ALUControlE)
            c_op_add: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_c   = w_sum[WIDTH];
                w_alu_v   = (w_a[WIDTH-1] == w_srcb[WIDTH-1]) &&
                            (w_sum[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_op_sub: begin
                w_alu_res = w_diff[WIDTH-1:0];
                w_alu_c   = w_diff[WIDTH];
                w_alu_v   = (w_a[WIDTH-1] != w_srcb[WIDTH-1]) &&
                            (w_diff[WIDTH-1] != w_a[WIDTH-1]);
            end
            c_op_and:  w_alu_res = w_a & w_srcb;
            c_op_or:   w_alu_res = w_a | w_srcb;
            c_op_xor:  w_alu_res = w_a ^ w_srcb;
            c_op_shl:  w_alu_res = w_a << w_srcb[c_sh_w-1:0];
            c_op_movb: w_alu_res = w_srcb;
            default:   w_alu_res = '0;  // MUL result comes from the sequencer
        endcase
    end

    // One shift-add step; on the last iteration this is already the product.
    assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : {WIDTH{1'b0}});

    assign w_is_mul        = (ex.ALUControlE == c_op_mul);
    assign w_mul_last      = (r_cnt == c_cnt_last);
    assign w_start_mul     = (r_state == IDLE) && ex.ValidE && w_is_mul && !ex.FlushE;
    assign w_commit_single = (r_state == IDLE) && ex.ValidE && !w_is_mul && !ex.FlushE;
    assign w_mul_done      = (r_state == BUSY) && w_mul_last && !ex.FlushE;

    assign ex.StallE = reset && !ex.FlushE &&
                       (((r_state == IDLE) && ex.ValidE && w_is_mul) ||
                        ((r_state == BUSY) && !w_mul_last));

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (ex.FlushE) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_start_mul) w_state_next = BUSY;
                BUSY:    if (w_mul_last)  w_state_next = IDLE;
                default: w_state_next = IDLE;
            endcase
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt            <= '0;
            r_acc            <= '0;
            r_mcand          <= '0;
            r_mplier         <= '0;
            r_mul_regwrite   <= 1'b0;
            r_mul_memtoreg   <= 1'b0;
            r_mul_memwrite   <= 1'b0;
            r_mul_flagswrite <= 1'b0;
            r_mul_wa3        <= '0;
            r_mul_wdata      <= '0;
        end else if (ex.FlushE) begin
            r_cnt <= '0;
        end else if (w_start_mul) begin
            r_cnt            <= '0;
            r_acc            <= '0;
            r_mcand          <= w_a;
            r_mplier         <= w_srcb;
            r_mul_regwrite   <= ex.RegWriteE;
            r_mul_memtoreg   <= ex.MemtoRegE;
            r_mul_memwrite   <= ex.MemWriteE;
            r_mul_flagswrite <= ex.FlagsWriteE;
            r_mul_wa3        <= ex.WA3E;
            r_mul_wdata      <= ex.rd2E;
        end else if (r_state == BUSY) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= w_mul_last ? '0 : r_cnt + 1'b1;
        end
    end

    // Every edge registers a bubble unless a result commits.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_validm    <= 1'b0;
            r_regwritem <= 1'b0;
            r_memtoregm <= 1'b0;
            r_memwritem <= 1'b0;
            r_wa3m      <= '0;
            r_resultm   <= '0;
            r_wdatam    <= '0;
        end else if (w_commit_single) begin
            r_validm    <= 1'b1;
            r_regwritem <= ex.RegWriteE;
            r_memtoregm <= ex.MemtoRegE;
            r_memwritem <= ex.MemWriteE;
            r_wa3m      <= ex.WA3E;
            r_resultm   <= w_alu_res;
            r_wdatam    <= ex.rd2E;
        end else if (w_mul_done) begin
            r_validm    <= 1'b1;
            r_regwritem <= r_mul_regwrite;
            r_memtoregm <= r_mul_memtoreg;
            r_memwritem <= r_mul_memwrite;
            r_wa3m      <= r_mul_wa3;
            r_resultm   <= w_acc_next;
            r_wdatam    <= r_mul_wdata;
        end else begin
            r_validm    <= 1'b0;
            r_regwritem <= 1'b0;
            r_memtoregm <= 1'b0;
            r_memwritem <= 1'b0;
            r_wa3m      <= '0;
            r_resultm   <= '0;
            r_wdatam    <= '0;
        end
    end

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_flags <= 4'b0000;
        end else if (w_commit_single && ex.FlagsWriteE) begin
            r_flags <= {w_alu_res[WIDTH-1], (w_alu_res == '0), w_alu_c, w_alu_v};
        end else if (w_mul_done && r_mul_flagswrite) begin
            r_flags <= {w_acc_next[WIDTH-1], (w_acc_next == '0), r_flags[1:0]};
        end
    end

    assign ex.ValidM     = r_validm;
    assign ex.RegWriteM  = r_regwritem;
    assign ex.MemtoRegM  = r_memtoregm;
    assign ex.MemWriteM  = r_memwritem;
    assign ex.WA3M       = r_wa3m;
    assign ex.ALUResultM = r_resultm;
    assign ex.WriteDataM = r_wdatam;
    assign ex.FlagsNZCV  = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_stage_execute.sv
`default_nettype none
// ============================================================================
// Module   : tb_stage_execute
// Purpose  : Self-checking bench: vector table, MUL/flush/reset sequences, result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stage_execute;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_MUL  = 3'b110;
    localparam logic [2:0] OP_MOVB = 3'b111;
    localparam int NV = 14;

    typedef struct {
        logic        valid;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic        src;
        logic        fw;
        logic        regw;
        logic        m2r;
        logic        memw;
        logic [3:0]  wa3;
        logic [31:0] res;
        logic [3:0]  nzcv;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  wa3;
        logic        regw;
        logic        m2r;
        logic        memw;
        logic [31:0] wdata;
        logic [3:0]  nzcv;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stage_execute_if #(.WIDTH(32)) bus ();
    stage_execute #(.WIDTH(32), .MUL_ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .ex    (bus.slave)
    );

    int         n_checks = 0;
    int         n_err    = 0;
    exp_t       sb[$];
    logic [3:0] m_flags  = 4'b0000;
    vec_t       vt[NV];

    task automatic chk(string name, logic [31:0] act, logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [31:0] mul_lo(logic [31:0] a, logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        return p[31:0];
    endfunction

    task automatic drive(vec_t v);
        bus.ValidE      = v.valid;
        bus.ALUControlE = v.op;
        bus.rd1E        = v.a;
        bus.rd2E        = v.b;
        bus.ExtImmE     = v.imm;
        bus.ALUSrcE     = v.src;
        bus.FlagsWriteE = v.fw;
        bus.RegWriteE   = v.regw;
        bus.MemtoRegE   = v.m2r;
        bus.MemWriteE   = v.memw;
        bus.WA3E        = v.wa3;
    endtask

    task automatic push_exp(vec_t v);
        exp_t e;
        e.res = v.res; e.wa3 = v.wa3; e.regw = v.regw; e.m2r = v.m2r;
        e.memw = v.memw; e.wdata = v.b; e.nzcv = v.nzcv;
        sb.push_back(e);
    endtask

    // One falling edge, then compare whatever the stage produced.
    task automatic tick(output bit seen);
        exp_t e;
        @(negedge clk);
        #1;
        seen = (bus.ValidM === 1'b1);
        if (seen) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_result: got ValidM=1 ALUResultM=%h required no output", bus.ALUResultM);
            end else begin
                e = sb.pop_front();
                chk("result",    bus.ALUResultM, e.res);
                chk("wa3m",      32'(bus.WA3M), 32'(e.wa3));
                chk("ctrl_m",    32'({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}),
                                 32'({e.regw, e.m2r, e.memw}));
                chk("writedata", bus.WriteDataM, e.wdata);
                chk("flags",     32'(bus.FlagsNZCV), 32'(e.nzcv));
                m_flags = e.nzcv;
            end
        end else begin
            chk("bubble_ctrl", 32'({bus.ValidM, bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}), 32'd0);
            chk("bubble_data", bus.ALUResultM, 32'd0);
            chk("flags_hold",  32'(bus.FlagsNZCV), 32'(m_flags));
        end
    endtask

    task automatic apply_vec(vec_t v);
        bit seen;
        drive(v);
        #1;
        chk("stall_single", 32'(bus.StallE), 32'd0);
        if (v.valid) push_exp(v);
        tick(seen);
        chk("commit_latency", 32'(seen), 32'(v.valid));
    endtask

    task automatic run_mul(vec_t v);
        bit seen;
        int n_stall;
        int done_edge;
        n_stall   = 0;
        done_edge = 0;
        drive(v);
        push_exp(v);
        for (int e = 1; e <= 40; e++) begin
            #1;
            if (bus.StallE === 1'b1) n_stall++;
            tick(seen);
            if (seen) begin
                done_edge = e;
                break;
            end
        end
        chk("mul_latency", done_edge, 32'd33);
        chk("mul_stall_cycles", n_stall, 32'd32);
        bus.ValidE = 1'b0;
        #1;
        chk("stall_after_mul", 32'(bus.StallE), 32'd0);
        tick(seen);
        chk("no_reaccept", 32'(seen), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bit   seen;
        vec_t v;
        logic [31:0] ra, ri;

        //          valid op       a             b             imm           src   fw    regw  m2r   memw  wa3    res           nzcv
        vt[0]  = '{1'b1, OP_ADD,  32'h7FFFFFFF, 32'h00000001, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1,  32'h80000000, 4'b1001};
        vt[1]  = '{1'b1, OP_SUB,  32'h00000005, 32'h0000AAAA, 32'h00000005, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2,  32'h00000000, 4'b0110};
        vt[2]  = '{1'b1, OP_XOR,  32'h0000000F, 32'h000000FF, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  32'h000000F0, 4'b0010};
        vt[3]  = '{1'b1, OP_AND,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0,        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4,  32'h0F000F00, 4'b0010};
        vt[4]  = '{1'b1, OP_OR,   32'h80000000, 32'h0000003C, 32'h00000001, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd5,  32'h80000001, 4'b1010};
        vt[5]  = '{1'b1, OP_SHL,  32'h00000001, 32'h00000024, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6,  32'h00000010, 4'b0010};
        vt[6]  = '{1'b1, OP_MOVB, 32'h11111111, 32'h00001234, 32'hDEADBEEF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd7,  32'hDEADBEEF, 4'b1010};
        vt[7]  = '{1'b1, OP_SUB,  32'h00000003, 32'h00000005, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd8,  32'hFFFFFFFE, 4'b1000};
        vt[8]  = '{1'b1, OP_ADD,  32'hFFFFFFFF, 32'h00000001, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd9,  32'h00000000, 4'b0110};
        vt[9]  = '{1'b1, OP_SUB,  32'h80000000, 32'h00000001, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd10, 32'h7FFFFFFF, 4'b0011};
        vt[10] = '{1'b0, OP_ADD,  32'h00000001, 32'h00000001, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd11, 32'h00000000, 4'b0011};
        vt[11] = '{1'b1, OP_ADD,  32'h00000100, 32'h00000055, 32'h00000004, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  32'h00000104, 4'b0011};
        vt[12] = '{1'b1, OP_ADD,  32'h00000100, 32'h00000000, 32'h00000008, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd15, 32'h00000108, 4'b0011};
        vt[13] = '{1'b1, OP_SHL,  32'hFFFFFFFF, 32'h0000001F, 32'h0,        1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd12, 32'h80000000, 4'b1011};

        bus.FlushE = 1'b0;
        v = '{1'b1, OP_MUL, 32'h3, 32'h4, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 32'h0, 4'b0};
        drive(v);
        #1 reset = 1'b0;
        #1;
        chk("stall_in_reset", 32'(bus.StallE), 32'd0);
        @(negedge clk);
        #1;
        chk("rst_validm", 32'(bus.ValidM), 32'd0);
        chk("rst_ctrl",   32'({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}), 32'd0);
        chk("rst_wa3m",   32'(bus.WA3M), 32'd0);
        chk("rst_result", bus.ALUResultM, 32'd0);
        chk("rst_wdata",  bus.WriteDataM, 32'd0);
        chk("rst_flags",  32'(bus.FlagsNZCV), 32'd0);
        bus.ValidE = 1'b0;
        reset      = 1'b1;

        for (int i = 0; i < NV; i++) apply_vec(vt[i]);

        // MUL 0x12345 x 0x100, flags untouched
        v = '{1'b1, OP_MUL, 32'h00012345, 32'h00000100, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 32'h01234500, 4'b1011};
        run_mul(v);

        v = '{1'b1, OP_SUB, 32'h5, 32'h5, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 32'h0, 4'b0110};
        apply_vec(v);
        // (-1)*(-1): N,Z update, C=1 V=0 survive from the SUB
        v = '{1'b1, OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 32'h00000001, 4'b0010};
        run_mul(v);

        for (int k = 0; k < 2; k++) begin
            ra = $urandom;
            ri = $urandom;
            v = '{1'b1, OP_MUL, ra, 32'h00000077, ri, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd9, mul_lo(ra, ri), 4'b0010};
            run_mul(v);
        end

        // Flush at cnt=10
        v = '{1'b1, OP_MUL, 32'h3, 32'h4, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 32'h0, 4'b0};
        drive(v);
        for (int e = 0; e < 11; e++) begin
            #1;
            chk("stall_busy", 32'(bus.StallE), 32'd1);
            tick(seen);
        end
        bus.FlushE = 1'b1;
        #1;
        chk("stall_flush", 32'(bus.StallE), 32'd0);
        tick(seen);
        chk("flush_bubble", 32'(seen), 32'd0);
        bus.FlushE = 1'b0;
        v = '{1'b1, OP_ADD, 32'h2, 32'h3, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 32'h5, 4'b0010};
        apply_vec(v);
        bus.ValidE = 1'b0;
        for (int e = 0; e < 25; e++) tick(seen);

        // Reset at cnt=20
        v = '{1'b1, OP_MUL, 32'h5, 32'h6, 32'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 32'h0, 4'b0};
        drive(v);
        for (int e = 0; e < 21; e++) tick(seen);
        reset = 1'b0;
        #1;
        chk("midrst_validm", 32'(bus.ValidM), 32'd0);
        chk("midrst_ctrl",   32'({bus.RegWriteM, bus.MemtoRegM, bus.MemWriteM}), 32'd0);
        chk("midrst_result", bus.ALUResultM, 32'd0);
        chk("midrst_flags",  32'(bus.FlagsNZCV), 32'd0);
        chk("midrst_stall",  32'(bus.StallE), 32'd0);
        m_flags = 4'b0000;
        tick(seen);
        bus.ValidE = 1'b0;
        reset      = 1'b1;
        for (int e = 0; e < 40; e++) tick(seen);

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
